// File: rtl/totd_pulse_gen_40mhz_if.sv
// Control, configuration and sample bus of the synthetic ToTd pulse generator.
// master drives the controls and reads the trace; slave is the generator side.
interface totd_pulse_gen_40mhz_if #(
  parameter int unsigned AdcWidth = 12,
  parameter int unsigned CntBits  = 8,
  parameter int unsigned GapBits  = 12
);
  logic [1:0]          enable40;
  logic                start;
  logic                stop;
  logic [AdcWidth-1:0] baseline;
  logic [AdcWidth-1:0] height;
  logic [CntBits-1:0]  width;
  logic [3:0]          decay_shift;
  logic [CntBits-1:0]  npulses;
  logic [GapBits-1:0]  gap;
  logic [AdcWidth-1:0] adc;
  logic                busy;
  logic                done;
  logic [CntBits-1:0]  pulse_cnt;

  modport master (
    output enable40, start, stop, baseline, height, width, decay_shift, npulses, gap,
    input  adc, busy, done, pulse_cnt
  );

  modport slave (
    input  enable40, start, stop, baseline, height, width, decay_shift, npulses, gap,
    output adc, busy, done, pulse_cnt
  );
endinterface

// File: rtl/totd_pulse_gen_40mhz.sv
// Synthetic PMT pulse-train source on the 120 MHz clock, advancing at the 40 MHz tick:
// baseline, flat top, shift-based exponential tail, programmable pulse count and gap.
module totd_pulse_gen_40mhz #(
  parameter int unsigned AdcWidth = 12,
  parameter int unsigned CntBits  = 8,
  parameter int unsigned GapBits  = 12
) (
  input logic                   clk120_i,
  input logic                   reset_i,
  totd_pulse_gen_40mhz_if.slave bus_io
);
  localparam int unsigned CntW = (GapBits > CntBits) ? GapBits : CntBits;

  typedef enum logic [1:0] {StIdle, StFlat, StTail, StGap} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lcl_en40_q;
  logic                start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;
  logic [AdcWidth-1:0] amp_q, amp_d, adc_q, adc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntBits-1:0]  pcnt_q, pcnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [AdcWidth-1:0] height_q;
  logic [CntBits-1:0]  width_q, npulses_q;
  logic [3:0]          shift_q;
  logic [GapBits-1:0]  gap_q;
  logic                tick, start_eff, stop_eff, accept, pulse_end;
  logic [CntW-1:0]     width_live, width_lat;
  logic [AdcWidth-1:0] tail_dec;
  logic [AdcWidth:0]   sum;

  assign tick       = (lcl_en40_q == 2'd0);
  assign start_eff  = start_pend_q | bus_io.start;
  assign stop_eff   = stop_pend_q | bus_io.stop;
  // A zero flat width still produces one flat sample
  assign width_live = (bus_io.width == '0) ? CntW'(1) : CntW'(bus_io.width);
  assign width_lat  = (width_q == '0) ? CntW'(1) : CntW'(width_q);
  assign tail_dec   = amp_q >> shift_q;

  always_comb begin
    state_d      = state_q;
    amp_d        = amp_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    adc_d        = adc_q;
    accept       = 1'b0;
    pulse_end    = 1'b0;
    sum          = '0;
    start_pend_d = start_eff;
    stop_pend_d  = stop_eff;
    if (tick) begin
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          amp_d = '0;
          if (start_eff) begin
            if (bus_io.npulses != '0) begin
              accept  = 1'b1;
              state_d = StFlat;
              cnt_d   = width_live;
              pcnt_d  = CntBits'(1);
              busy_d  = 1'b1;
            end else begin
              done_d = 1'b1;
              pcnt_d = '0;
            end
          end
        end
        StFlat: begin
          amp_d = height_q;
          if (cnt_q > CntW'(1)) cnt_d = cnt_q - 1'b1;
          else if (shift_q != 4'd0) state_d = StTail;
          else pulse_end = 1'b1;
        end
        StTail: begin
          if (tail_dec == '0) begin
            amp_d     = '0;
            pulse_end = 1'b1;
          end else begin
            amp_d = amp_q - tail_dec;
          end
        end
        StGap: begin
          amp_d = '0;
          if (cnt_q > CntW'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = StFlat;
            cnt_d   = width_lat;
            pcnt_d  = pcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      // End of a pulse is decided in the same tick that emits its last sample
      if (pulse_end) begin
        if (pcnt_q < npulses_q) begin
          if (gap_q != '0) begin
            state_d = StGap;
            cnt_d   = CntW'(gap_q);
          end else begin
            state_d = StFlat;
            cnt_d   = width_lat;
            pcnt_d  = pcnt_q + 1'b1;
          end
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      if (stop_eff) begin
        state_d = StIdle;
        amp_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;
        accept  = 1'b0;
      end
      sum   = {1'b0, bus_io.baseline} + {1'b0, amp_d};
      adc_d = sum[AdcWidth] ? '1 : sum[AdcWidth-1:0];
    end
  end

  always_ff @(posedge clk120_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      lcl_en40_q   <= 2'b11;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      amp_q        <= '0;
      adc_q        <= '0;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      height_q     <= '0;
      width_q      <= '0;
      shift_q      <= '0;
      npulses_q    <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      lcl_en40_q   <= bus_io.enable40;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      amp_q        <= amp_d;
      adc_q        <= adc_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (accept) begin
        height_q  <= bus_io.height;
        width_q   <= bus_io.width;
        shift_q   <= bus_io.decay_shift;
        npulses_q <= bus_io.npulses;
        gap_q     <= bus_io.gap;
      end
    end
  end

  assign bus_io.adc       = adc_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.pulse_cnt = pcnt_q;
endmodule

// File: tb/tb_totd_pulse_gen_40mhz.sv
// Bench for totd_pulse_gen_40mhz: fixed vectors, hand sequences for stop/reset corners,
// and random pulse trains checked against a sample-list model of the trace.
module tb_totd_pulse_gen_40mhz;
  localparam int unsigned AW = 12;
  localparam int unsigned CB = 8;
  localparam int unsigned GB = 12;

  typedef struct {
    int unsigned base, height, width, shift, npulses, gap;
  } cfg_t;

  typedef struct {
    cfg_t        c;
    int unsigned exp_adc[16];
    int          done_j;
    int unsigned exp_pcnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  totd_pulse_gen_40mhz_if #(.AdcWidth(AW), .CntBits(CB), .GapBits(GB)) bus ();

  totd_pulse_gen_40mhz #(.AdcWidth(AW), .CntBits(CB), .GapBits(GB)) dut (
    .clk120_i (clk),
    .reset_i  (rst),
    .bus_io   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  lcl_m   = 2'd3;
  bit          tick_now;
  int unsigned seq[$];
  int unsigned starts[$];
  vec_t        tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; tracks whether this edge advanced the generator (registered phase was 0).
  task automatic cyc();
    logic was_rst;
    was_rst = rst;
    @(posedge clk);
    #1;
    tick_now = !was_rst && (lcl_m == 2'd0);
    lcl_m    = was_rst ? 2'd3 : bus.enable40;
    bus.enable40 = (bus.enable40 == 2'd2) ? 2'd0 : bus.enable40 + 2'd1;
    if (!was_rst && !tick_now) check("done_off_tick", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic next_tick();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick_now && k < 8);
    if (!tick_now) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_and_tick(input logic s, input logic p);
    bus.start = s;
    bus.stop  = p;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (!tick_now) next_tick();
  endtask

  task automatic set_cfg(input cfg_t c);
    bus.baseline    = AW'(c.base);
    bus.height      = AW'(c.height);
    bus.width       = CB'(c.width);
    bus.decay_shift = 4'(c.shift);
    bus.npulses     = CB'(c.npulses);
    bus.gap         = GB'(c.gap);
  endtask

  // Amplitude emitted at each tick from the accepting tick onward, and pulse start indices.
  task automatic build(input cfg_t c);
    int unsigned a;
    seq.delete();
    starts.delete();
    seq.push_back(0);
    for (int p = 0; p < int'(c.npulses); p++) begin
      if (p > 0) repeat (c.gap) seq.push_back(0);
      starts.push_back(seq.size());
      repeat ((c.width == 0) ? 1 : c.width) seq.push_back(c.height);
      if (c.shift != 0) begin
        a = c.height;
        while (1) begin
          if ((a >> c.shift) == 0) begin
            seq.push_back(0);
            break;
          end
          a = a - (a >> c.shift);
          seq.push_back(a);
        end
      end
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic int unsigned started_by(input int idx);
    int unsigned n;
    n = 0;
    foreach (starts[i]) if (int'(starts[i]) <= idx) n++;
    return n;
  endfunction

  // mode 0: plain, 1: STOP effective at tick k, 2: START while busy at tick k
  task automatic run_train(input cfg_t c, input int mode, input int k);
    int          n;
    int unsigned amp, pc;
    bit          stopped;
    build(c);
    n = seq.size() - 1;
    set_cfg(c);
    repeat ($urandom_range(0, 2)) cyc();
    pulse_and_tick(1'b1, 1'b0);
    for (int j = 0; j <= n + 2; j++) begin
      if (j > 0) begin
        if (mode != 0 && j == k) pulse_and_tick(mode == 2, mode == 1);
        else next_tick();
      end
      stopped = (mode == 1) && (j >= k);
      amp     = (!stopped && j <= n) ? seq[j] : 0;
      pc      = stopped ? started_by(k) : started_by(j + 1);
      check("rnd_adc", bus.adc, sat(c.base + amp));
      check("rnd_busy", {31'd0, bus.busy}, {31'd0, (c.npulses != 0) && (j < n) && !stopped});
      check("rnd_done", {31'd0, bus.done}, {31'd0, (j == n) && !stopped});
      check("rnd_pcnt", bus.pulse_cnt, pc);
    end
  endtask

  initial begin
    cfg_t c;
    int   dcnt, n, mode, k;

    bus.enable40 = 2'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    c = '{base: 123, height: 0, width: 1, shift: 0, npulses: 1, gap: 0};
    set_cfg(c);

    tbl[0].c = '{base: 50, height: 100, width: 2, shift: 1, npulses: 1, gap: 0};
    tbl[0].exp_adc = '{50, 150, 150, 100, 75, 63, 57, 54, 52, 51, 50, 50, 50, 50, 50, 50};
    tbl[0].done_j = 10; tbl[0].exp_pcnt = 1;
    tbl[1].c = '{base: 4000, height: 500, width: 3, shift: 0, npulses: 1, gap: 0};
    tbl[1].exp_adc = '{4000, 4095, 4095, 4095, 4000, 4000, 4000, 4000,
                       4000, 4000, 4000, 4000, 4000, 4000, 4000, 4000};
    tbl[1].done_j = 3; tbl[1].exp_pcnt = 1;
    tbl[2].c = '{base: 10, height: 20, width: 1, shift: 0, npulses: 3, gap: 5};
    tbl[2].exp_adc = '{10, 30, 10, 10, 10, 10, 10, 30, 10, 10, 10, 10, 10, 30, 10, 10};
    tbl[2].done_j = 13; tbl[2].exp_pcnt = 3;
    tbl[3].c = '{base: 777, height: 300, width: 2, shift: 1, npulses: 0, gap: 0};
    tbl[3].exp_adc = '{777, 777, 777, 777, 777, 777, 777, 777,
                       777, 777, 777, 777, 777, 777, 777, 777};
    tbl[3].done_j = 0; tbl[3].exp_pcnt = 0;
    tbl[4].c = '{base: 100, height: 7, width: 0, shift: 3, npulses: 1, gap: 0};
    tbl[4].exp_adc = '{100, 107, 100, 100, 100, 100, 100, 100,
                       100, 100, 100, 100, 100, 100, 100, 100};
    tbl[4].done_j = 2; tbl[4].exp_pcnt = 1;
    tbl[5].c = '{base: 0, height: 8, width: 1, shift: 1, npulses: 2, gap: 0};
    tbl[5].exp_adc = '{0, 8, 4, 2, 1, 0, 8, 4, 2, 1, 0, 0, 0, 0, 0, 0};
    tbl[5].done_j = 10; tbl[5].exp_pcnt = 2;

    // Reset state and live idle baseline
    repeat (3) cyc();
    check("rst_adc", bus.adc, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_pcnt", bus.pulse_cnt, 32'd0);
    rst = 1'b0;
    next_tick();
    check("idle_adc", bus.adc, 32'd123);
    bus.baseline = 12'd321;
    next_tick();
    check("idle_live", bus.adc, 32'd321);

    foreach (tbl[i]) begin
      set_cfg(tbl[i].c);
      repeat (i % 3) cyc();
      pulse_and_tick(1'b1, 1'b0);
      for (int j = 0; j < 16; j++) begin
        if (j > 0) next_tick();
        check($sformatf("vec%0d_adc%0d", i, j), bus.adc, tbl[i].exp_adc[j]);
        check($sformatf("vec%0d_busy%0d", i, j), {31'd0, bus.busy},
              {31'd0, (tbl[i].c.npulses != 0) && (j < tbl[i].done_j)});
        check($sformatf("vec%0d_done%0d", i, j), {31'd0, bus.done}, {31'd0, j == tbl[i].done_j});
      end
      check($sformatf("vec%0d_pcnt", i), bus.pulse_cnt, tbl[i].exp_pcnt);
    end

    // START and STOP landing on the same tick: nothing starts, count holds
    c = '{base: 200, height: 50, width: 2, shift: 0, npulses: 2, gap: 1};
    set_cfg(c);
    pulse_and_tick(1'b1, 1'b1);
    check("ss_busy", {31'd0, bus.busy}, 32'd0);
    check("ss_adc", bus.adc, 32'd200);
    check("ss_done", {31'd0, bus.done}, 32'd0);
    check("ss_pcnt", bus.pulse_cnt, 32'd2);
    next_tick();
    check("ss_busy2", {31'd0, bus.busy}, 32'd0);

    // Single-cycle START on a non-tick phase, then reset mid-flat
    c = '{base: 60, height: 40, width: 5, shift: 0, npulses: 1, gap: 0};
    set_cfg(c);
    next_tick();
    pulse_and_tick(1'b1, 1'b0);
    check("nt_busy", {31'd0, bus.busy}, 32'd1);
    check("nt_adc0", bus.adc, 32'd60);
    next_tick();
    check("nt_adc1", bus.adc, 32'd100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mr_adc", bus.adc, 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_pcnt", bus.pulse_cnt, 32'd0);
    dcnt = 0;
    repeat (30) begin
      cyc();
      if (bus.done) dcnt++;
    end
    check("mr_no_done", dcnt, 32'd0);
    check("mr_idle_adc", bus.adc, 32'd60);

    // Random trains, some aborted by STOP or poked with START while busy
    for (int t = 0; t < 40; t++) begin
      c.base    = (t % 4 == 0) ? $urandom_range(3500, 4095) : $urandom_range(0, 4095);
      c.height  = $urandom_range(0, 4095);
      c.width   = $urandom_range(0, 4);
      c.shift   = $urandom_range(0, 3);
      c.npulses = $urandom_range(0, 3);
      c.gap     = $urandom_range(0, 4);
      build(c);
      n    = seq.size() - 1;
      mode = (n >= 1) ? $urandom_range(0, 2) : 0;
      k    = (n >= 1) ? $urandom_range(1, n) : 0;
      run_train(c, mode, k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
